stopwatch_ctrl: RTL and testbench

Control and timekeeping core of the FPGA stopwatch. It consumes the cleaned button pulses from the debounce stage (start/stop, lap, clear) and runs a four-state control FSM. A prescaler derives a 1/100 s tick from clk, which drives a BCD mm:ss.cc counter. The block presents either the live time or a frozen lap value to the display driver.

---
 rtl/stopwatch_pkg.sv | 22 ++
 rtl/bcd_digit_cnt.sv | 34 +++
 rtl/stopwatch_ctrl.sv | 126 ++++++++++++
 tb/tb_stopwatch_ctrl.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch control core.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    LAP   = 2'd3
  } sw_state_e;

  localparam int DIG_MAX_DEC  = 9;
  localparam int DIG_MAX_HEX6 = 5;
  localparam int NUM_DIG      = 6;

  typedef logic [3:0] bcd_digit_t;

  // Digit order is c1,c10,s1,s10,m1,m10; the tens of seconds/minutes stop at 5.
  function automatic int digit_max(input int idx);
    return (idx == 3 || idx == 5) ? DIG_MAX_HEX6 : DIG_MAX_DEC;
  endfunction

endpackage

// File: rtl/bcd_digit_cnt.sv
// One BCD digit of the time counter; carry is combinational so a chain ripples in one cycle.
module bcd_digit_cnt
  import stopwatch_pkg::*;
#(
  parameter int MAX = DIG_MAX_DEC
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       inc,
  output bcd_digit_t q,
  output logic       carry
);

  bcd_digit_t q_q, q_d;
  logic       at_max;

  assign at_max = (q_q == bcd_digit_t'(MAX));

  always_comb begin
    q_d = q_q;
    if (clr)      q_d = '0;
    else if (inc) q_d = at_max ? '0 : q_q + 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= '0;
    else        q_q <= q_d;
  end

  assign q     = q_q;
  assign carry = inc & at_max;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: button edge detect, 4-state FSM, 1/100 s prescaler,
// mm:ss.cc BCD counter and lap latch feeding the display.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 100,
  parameter int PRE_W   = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_start_stop,
  input  logic        btn_lap,
  input  logic        btn_clear,
  output logic [23:0] time_bcd,
  output logic        run,
  output logic        lap_active,
  output logic        overflow,
  output logic [1:0]  state
);

  localparam int               TICK_DIV = CLK_HZ / TICK_HZ;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  logic             ss_q, lap_q, clr_q;
  logic             ss_rise, lap_rise, clr_rise;
  sw_state_e        state_q, state_d;
  logic             run_q, run_d, lap_act_q, lap_act_d, ovf_q, ovf_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [23:0]      lap_latch_q, lap_latch_d;
  logic             running, tick, go_clear, go_latch;
  logic [NUM_DIG-1:0] dig_inc, dig_carry;
  logic [23:0]      live_bcd;

  // Debouncer output is already synchronous; a single register is enough for edges.
  assign ss_rise  = btn_start_stop & ~ss_q;
  assign lap_rise = btn_lap & ~lap_q;
  assign clr_rise = btn_clear & ~clr_q;

  assign running = (state_q == RUN) || (state_q == LAP);
  assign tick    = running && (pre_q == PRE_LAST);

  // Priority clear > start_stop > lap, among edges legal in the current state.
  always_comb begin
    state_d  = state_q;
    go_clear = 1'b0;
    go_latch = 1'b0;
    case (state_q)
      IDLE: if (ss_rise) state_d = RUN;
      RUN, LAP: begin
        if (ss_rise) state_d = PAUSE;
        else if (lap_rise) begin
          state_d  = LAP;
          go_latch = 1'b1;
        end
      end
      PAUSE: begin
        if (clr_rise) begin
          state_d  = IDLE;
          go_clear = 1'b1;
        end else if (ss_rise) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    run_d       = (state_d == RUN) || (state_d == LAP);
    lap_act_d   = (state_d == LAP);
    lap_latch_d = go_latch ? live_bcd : lap_latch_q;
    pre_d       = pre_q;
    if (go_clear)     pre_d = '0;
    else if (tick)    pre_d = '0;
    else if (running) pre_d = pre_q + PRE_W'(1);
    ovf_d = ovf_q;
    if (go_clear)                ovf_d = 1'b0;
    else if (dig_carry[NUM_DIG-1]) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_q        <= 1'b0;
      lap_q       <= 1'b0;
      clr_q       <= 1'b0;
      state_q     <= IDLE;
      run_q       <= 1'b0;
      lap_act_q   <= 1'b0;
      ovf_q       <= 1'b0;
      pre_q       <= '0;
      lap_latch_q <= '0;
    end else begin
      ss_q        <= btn_start_stop;
      lap_q       <= btn_lap;
      clr_q       <= btn_clear;
      state_q     <= state_d;
      run_q       <= run_d;
      lap_act_q   <= lap_act_d;
      ovf_q       <= ovf_d;
      pre_q       <= pre_d;
      lap_latch_q <= lap_latch_d;
    end
  end

  for (genvar i = 0; i < NUM_DIG; i++) begin : g_dig
    if (i == 0) begin : g_lsd
      assign dig_inc[i] = tick;
    end else begin : g_up
      assign dig_inc[i] = dig_carry[i-1];
    end
    bcd_digit_cnt #(.MAX(digit_max(i))) u_dig (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (go_clear),
      .inc   (dig_inc[i]),
      .q     (live_bcd[4*i +: 4]),
      .carry (dig_carry[i])
    );
  end

  assign time_bcd   = (state_q == LAP) ? lap_latch_q : live_bcd;
  assign state      = state_q;
  assign run        = run_q;
  assign lap_active = lap_act_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: centisecond reference model feeding a per-cycle
// scoreboard, plus a table of stimulus segments with fixed expected endpoints.
module tb_stopwatch_ctrl;
  localparam int TDIV   = 10;
  localparam int CS_MAX = 359999;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        btn_ss = 1'b0, btn_lap = 1'b0, btn_clr = 1'b0;
  logic [23:0] time_bcd;
  logic        run, lap_active, overflow;
  logic [1:0]  state;

  stopwatch_ctrl #(.CLK_HZ(1000), .TICK_HZ(100), .PRE_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .btn_start_stop(btn_ss), .btn_lap(btn_lap),
    .btn_clear(btn_clr), .time_bcd(time_bcd), .run(run),
    .lap_active(lap_active), .overflow(overflow), .state(state)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;

  int m_st, m_pre, m_cs, m_lap;
  bit m_ovf, m_pss, m_plp, m_pcl;
  logic [28:0] sb_q[$];

  typedef struct {
    string       name;
    bit          ss, lp, cl;
    int          on, idle;
    logic [23:0] t;
    logic [1:0]  st;
    bit          r, la, ov;
  } vec_t;
  vec_t tbl[$];

  function automatic logic [23:0] to_bcd(input int cs);
    int m, s, c;
    m = cs / 6000; s = (cs / 100) % 60; c = cs % 100;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(c / 10), 4'(c % 10)};
  endfunction

  function automatic logic [28:0] m_obs();
    return {to_bcd(m_st == 3 ? m_lap : m_cs), 2'(m_st),
            1'(m_st == 1 || m_st == 3), 1'(m_st == 3), m_ovf};
  endfunction

  function automatic logic [28:0] obs();
    return {time_bcd, state, run, lap_active, overflow};
  endfunction

  task automatic m_reset();
    m_st = 0; m_pre = 0; m_cs = 0; m_lap = 0;
    m_ovf = 0; m_pss = 0; m_plp = 0; m_pcl = 0;
  endtask

  task automatic m_edge(input bit ss, input bit lp, input bit cl);
    bit rs, rl, rc, running, tick;
    int cs_old, nst;
    rs = ss && !m_pss; rl = lp && !m_plp; rc = cl && !m_pcl;
    m_pss = ss; m_plp = lp; m_pcl = cl;
    cs_old  = m_cs;
    running = (m_st == 1 || m_st == 3);
    tick    = running && (m_pre == TDIV - 1);
    if (running) m_pre = tick ? 0 : m_pre + 1;
    if (tick) begin
      if (m_cs == CS_MAX) begin m_cs = 0; m_ovf = 1; end
      else m_cs = m_cs + 1;
    end
    nst = m_st;
    case (m_st)
      0: if (rs) nst = 1;
      1, 3: if (rs) nst = 2;
            else if (rl) begin nst = 3; m_lap = cs_old; end
      2: if (rc) begin nst = 0; m_pre = 0; m_cs = 0; m_ovf = 0; end
         else if (rs) nst = 1;
      default: nst = 0;
    endcase
    m_st = nst;
  endtask

  task automatic check(input string name, input logic [28:0] act, input logic [28:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got time=%h st=%0d run=%b lap=%b ovf=%b, want time=%h st=%0d run=%b lap=%b ovf=%b",
               name, act[28:5], act[4:3], act[2], act[1], act[0],
               exp[28:5], exp[4:3], exp[2], exp[1], exp[0]);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs sampled at the same offset.
  task automatic step(input bit ss, input bit lp, input bit cl);
    btn_ss = ss; btn_lap = lp; btn_clr = cl;
    m_edge(ss, lp, cl);
    sb_q.push_back(m_obs());
    @(posedge clk); #1;
    check("sb", obs(), sb_q.pop_front());
  endtask

  task automatic add(input string name, input bit ss, input bit lp, input bit cl,
                     input int on, input int idle, input logic [23:0] t,
                     input logic [1:0] st, input bit r, input bit la, input bit ov);
    vec_t v;
    v.name = name; v.ss = ss; v.lp = lp; v.cl = cl; v.on = on; v.idle = idle;
    v.t = t; v.st = st; v.r = r; v.la = la; v.ov = ov;
    tbl.push_back(v);
  endtask

  task automatic apply(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      for (int k = 0; k < tbl[i].on; k++) step(tbl[i].ss, tbl[i].lp, tbl[i].cl);
      for (int k = 0; k < tbl[i].idle; k++) step(1'b0, 1'b0, 1'b0);
      check(tbl[i].name, obs(), {tbl[i].t, tbl[i].st, tbl[i].r, tbl[i].la, tbl[i].ov});
    end
  endtask

  initial begin
    //   name            ss lp cl on idle  time        st    r  la ov
    add("idle_ignore",   0, 1, 1, 1,   2, 24'h000000, 2'd0, 0, 0, 0); // 0
    add("start_100",     1, 0, 0, 1, 100, 24'h000010, 2'd1, 1, 0, 0); // 1
    add("pause_hold",    1, 0, 0, 1,  50, 24'h000010, 2'd2, 0, 0, 0); // 2
    add("resume_25",     1, 0, 0, 1, 149, 24'h000025, 2'd1, 1, 0, 0); // 3
    add("lap_frozen",    0, 1, 0, 1, 300, 24'h000025, 2'd3, 1, 1, 0); // 4
    add("lap_split",     0, 1, 0, 1,   0, 24'h000055, 2'd3, 1, 1, 0); // 5
    add("lap_to_pause",  1, 0, 0, 1,   5, 24'h000055, 2'd2, 0, 0, 0); // 6
    add("pre_wrap",      1, 0, 0, 1,   6, 24'h595999, 2'd1, 1, 0, 0); // 7
    add("wrap",          0, 0, 0, 0,   1, 24'h000000, 2'd1, 1, 0, 1); // 8
    add("after_wrap",    0, 0, 0, 0,  10, 24'h000001, 2'd1, 1, 0, 1); // 9
    add("pause_ovf",     1, 0, 0, 1,   2, 24'h000001, 2'd2, 0, 0, 1); // 10
    add("clr_beats_ss",  1, 0, 1, 1,   2, 24'h000000, 2'd0, 0, 0, 0); // 11
    add("held_start",    1, 0, 0, 40, 20, 24'h000005, 2'd1, 1, 0, 0); // 12
    add("clr_in_run",    0, 0, 1, 1,   0, 24'h000006, 2'd1, 1, 0, 0); // 13
    add("ss_beats_lap",  1, 1, 0, 1,   0, 24'h000006, 2'd2, 0, 0, 0); // 14
    add("lap_in_pause",  0, 1, 0, 1,   3, 24'h000006, 2'd2, 0, 0, 0); // 15
    add("run_again",     1, 0, 0, 1,  30, 24'h000009, 2'd1, 1, 0, 0); // 16

    m_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", obs(), 29'd0);
    rst_n = 1'b1;

    apply(0, 6);

    // Jump the live counter to 59:59.99 while paused.
    force dut.g_dig[0].u_dig.q_q = 4'd9;
    force dut.g_dig[1].u_dig.q_q = 4'd9;
    force dut.g_dig[2].u_dig.q_q = 4'd9;
    force dut.g_dig[3].u_dig.q_q = 4'd5;
    force dut.g_dig[4].u_dig.q_q = 4'd9;
    force dut.g_dig[5].u_dig.q_q = 4'd5;
    @(negedge clk);
    release dut.g_dig[0].u_dig.q_q;
    release dut.g_dig[1].u_dig.q_q;
    release dut.g_dig[2].u_dig.q_q;
    release dut.g_dig[3].u_dig.q_q;
    release dut.g_dig[4].u_dig.q_q;
    release dut.g_dig[5].u_dig.q_q;
    m_cs = CS_MAX;
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("preload", obs(), {24'h595999, 2'd2, 1'b0, 1'b0, 1'b0});

    apply(7, 16);

    // Asynchronous reset in RUN: outputs must clear before any clock edge.
    rst_n = 1'b0;
    #1;
    check("reset_async", obs(), 29'd0);
    btn_ss = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_held", obs(), 29'd0);
    m_reset();
    rst_n = 1'b1;
    step(1'b1, 1'b0, 1'b0);
    check("start_at_release", obs(), {24'h000000, 2'd1, 1'b1, 1'b0, 1'b0});
    step(1'b0, 1'b0, 1'b0);

    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain: got %0d entries left, want 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
